// File: rtl/crc_frame_scheduler_if.sv
// Request/codeword bundle shared by crc_frame_scheduler and its environment.
// The scheduler side uses the slave modport; sources/sinks use master.
interface crc_frame_scheduler_if #(
  parameter int MSG_W = 10,
  parameter int CRC_W = 8
);
  logic [1:0]             req_valid;
  logic [MSG_W-1:0]       req_data0;
  logic [MSG_W-1:0]       req_data1;
  logic [1:0]             req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [MSG_W+CRC_W-1:0] out_data;
  logic [CRC_W-1:0]       out_crc;
  logic                   out_src;
  logic                   busy;

  modport master (
    output req_valid, req_data0, req_data1, out_ready,
    input  req_ready, out_valid, out_data, out_crc, out_src, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, out_ready,
    output req_ready, out_valid, out_data, out_crc, out_src, busy
  );
endinterface

// File: rtl/crc_frame_scheduler.sv
// Time-shares one 2-bit-per-cycle CRC LFSR between two requesters using a
// round-robin arbiter, then presents {message, remainder} on a valid/ready port.
module crc_frame_scheduler #(
  parameter int               MSG_W = 10,
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07,
  parameter logic [CRC_W-1:0] INIT  = 8'h00
) (
  input logic                   clk,
  input logic                   reset,
  crc_frame_scheduler_if.slave  bus
);

  localparam int CNT_W = (MSG_W / 2 > 1) ? $clog2(MSG_W / 2) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_W / 2 - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state;
  logic [MSG_W-1:0]       msg_reg;
  logic [MSG_W-1:0]       shift_reg;
  logic [CRC_W-1:0]       lfsr;
  logic [CNT_W-1:0]       cnt;
  logic                   src;
  logic                   last_grant;
  logic                   busy_q;
  logic                   out_valid_q;
  logic [MSG_W+CRC_W-1:0] out_data_q;
  logic [CRC_W-1:0]       out_crc_q;
  logic                   out_src_q;

  logic [1:0]             grant;
  logic                   xfer;
  logic                   xfer_idx;
  logic [CRC_W-1:0]       lfsr_half;
  logic [CRC_W-1:0]       lfsr_next;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic             b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return (r << 1) ^ (fb ? POLY : '0);
  endfunction

  // Round-robin: under contention the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign xfer     = |(grant & bus.req_valid);
  assign xfer_idx = grant[1];

  // Two unfolded serial steps per clock, higher message bit first.
  always_comb begin
    lfsr_half = crc_step(lfsr, shift_reg[MSG_W-1]);
    lfsr_next = crc_step(lfsr_half, shift_reg[MSG_W-2]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      msg_reg     <= '0;
      shift_reg   <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      src         <= 1'b0;
      last_grant  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_crc_q   <= '0;
      out_src_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            msg_reg    <= xfer_idx ? bus.req_data1 : bus.req_data0;
            shift_reg  <= xfer_idx ? bus.req_data1 : bus.req_data0;
            src        <= xfer_idx;
            last_grant <= xfer_idx;
            lfsr       <= INIT;
            cnt        <= '0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr      <= lfsr_next;
          shift_reg <= shift_reg << 2;
          cnt       <= cnt + CNT_W'(1);
          // The codeword is registered on the final step so it is stable for all of HOLD.
          if (cnt == LAST_CNT) begin
            out_valid_q <= 1'b1;
            out_crc_q   <= lfsr_next;
            out_data_q  <= {msg_reg, lfsr_next};
            out_src_q   <= src;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_crc   = out_crc_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Directed bench for crc_frame_scheduler at default parameters; expected
// remainders are hand-computed for POLY = x^8+x^2+x+1, INIT = 0.
module tb_crc_frame_scheduler;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   check_cnt;

  crc_frame_scheduler_if #(.MSG_W(10), .CRC_W(8)) bus ();

  crc_frame_scheduler #(
    .MSG_W(10), .CRC_W(8), .POLY(8'h07), .INIT(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for out_valid at negedges; n = number of negedges crossed (bounded).
  task automatic await_valid(input logic [1:0] after_valid, output int n);
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) bus.req_valid = after_valid;
      n++;
    end while (!bus.out_valid && n < 20);
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.out_ready = 1'b0;
    #1;
    check_cnt++;
    if ({bus.req_ready, bus.out_valid, bus.out_src, bus.busy} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got rdy=%b vld=%b src=%b busy=%b want all 0",
               bus.req_ready, bus.out_valid, bus.out_src, bus.busy);
    else pass_cnt++;
    check_cnt++;
    if ({bus.out_data, bus.out_crc} !== 26'h0)
      $display("[TB] FAIL reset_data: got data=%h crc=%h want 0", bus.out_data, bus.out_crc);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_frame();
    int n;
    bus.req_valid = 2'b01;
    bus.req_data0 = 10'b1100000011;
    bus.out_ready = 1'b1;
    #1;
    check_cnt++;
    if (bus.req_ready !== 2'b01) $display("[TB] FAIL single_grant: got %b want 01", bus.req_ready);
    else pass_cnt++;
    await_valid(2'b00, n);
    check_cnt++;
    if (n !== 6) $display("[TB] FAIL single_latency: got %0d want 6", n);
    else pass_cnt++;
    check_cnt++;
    if (bus.out_crc !== 8'h36) $display("[TB] FAIL single_crc: got %h want 36", bus.out_crc);
    else pass_cnt++;
    check_cnt++;
    if (bus.out_data !== 18'h30336) $display("[TB] FAIL single_data: got %h want 30336", bus.out_data);
    else pass_cnt++;
    check_cnt++;
    if ({bus.out_src, bus.busy} !== 2'b01)
      $display("[TB] FAIL single_src_busy: got src=%b busy=%b want 0 1", bus.out_src, bus.busy);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.out_valid, bus.busy} !== 2'b00)
      $display("[TB] FAIL single_done: got vld=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_requester1();
    int n;
    bus.req_valid = 2'b10;
    bus.req_data1 = 10'h001;
    bus.out_ready = 1'b1;
    #1;
    check_cnt++;
    if (bus.req_ready !== 2'b10) $display("[TB] FAIL req1_grant: got %b want 10", bus.req_ready);
    else pass_cnt++;
    await_valid(2'b00, n);
    check_cnt++;
    if (n !== 6) $display("[TB] FAIL req1_latency: got %0d want 6", n);
    else pass_cnt++;
    check_cnt++;
    if ({bus.out_crc, bus.out_data, bus.out_src} !== {8'h07, 18'h00107, 1'b1})
      $display("[TB] FAIL req1_out: got crc=%h data=%h src=%b want 07 00107 1",
               bus.out_crc, bus.out_data, bus.out_src);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.out_valid, bus.out_crc} !== {1'b0, 8'h07})
      $display("[TB] FAIL req1_hold_last: got vld=%b crc=%h want 0 07", bus.out_valid, bus.out_crc);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    bus.req_valid = 2'b01;
    bus.req_data0 = 10'h200;
    bus.req_data1 = 10'h000;
    bus.out_ready = 1'b0;
    await_valid(2'b10, n);
    check_cnt++;
    if (n !== 6) $display("[TB] FAIL bp_latency: got %0d want 6", n);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      check_cnt++;
      if ({bus.out_valid, bus.out_data, bus.out_crc, bus.out_src, bus.req_ready} !==
          {1'b1, 18'h2002A, 8'h2A, 1'b0, 2'b00})
        $display("[TB] FAIL bp_stable[%0d]: got vld=%b data=%h crc=%h src=%b rdy=%b want 1 2002a 2a 0 00",
                 i, bus.out_valid, bus.out_data, bus.out_crc, bus.out_src, bus.req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({bus.out_valid, bus.req_ready} !== {1'b0, 2'b10})
      $display("[TB] FAIL bp_after_hs: got vld=%b rdy=%b want 0 10", bus.out_valid, bus.req_ready);
    else pass_cnt++;
    await_valid(2'b00, n);
    check_cnt++;
    if (n !== 6) $display("[TB] FAIL bp_single_hs: got %0d want 6", n);
    else pass_cnt++;
    check_cnt++;
    if ({bus.out_crc, bus.out_src} !== {8'h00, 1'b1})
      $display("[TB] FAIL zero_msg: got crc=%h src=%b want 00 1", bus.out_crc, bus.out_src);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bus.req_valid = 2'b01;
    bus.req_data0 = 10'b1100000011;
    bus.req_data1 = 10'h001;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_cnt++;
    if ({bus.req_ready, bus.out_valid, bus.out_src, bus.busy, bus.out_data, bus.out_crc} !== 31'h0)
      $display("[TB] FAIL rst_async: got rdy=%b vld=%b src=%b busy=%b data=%h crc=%h want all 0",
               bus.req_ready, bus.out_valid, bus.out_src, bus.busy, bus.out_data, bus.out_crc);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_discard: got vld=%b want 0", bus.out_valid);
    else pass_cnt++;
    bus.req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (bus.req_ready !== 2'b01) $display("[TB] FAIL rst_first_grant: got %b want 01", bus.req_ready);
    else pass_cnt++;
    await_valid(2'b00, n);
    check_cnt++;
    if ({n[4:0], bus.out_crc, bus.out_src} !== {5'd6, 8'h36, 1'b0})
      $display("[TB] FAIL rst_next_frame: got n=%0d crc=%h src=%b want 6 36 0", n, bus.out_crc, bus.out_src);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int grants[$];
    int gcyc[$];
    int srcs[$];
    int crcs[$];
    int exp_idx[4] = '{0, 1, 0, 1};
    int exp_crc[4] = '{8'h36, 8'h07, 8'h36, 8'h07};
    reset = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_data0 = 10'b1100000011;
    bus.req_data1 = 10'h001;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    for (int cyc = 0; cyc < 60 && srcs.size() < 4; cyc++) begin
      if (grants.size() == 4) bus.req_valid = 2'b00;
      #1;
      if ((bus.req_ready & bus.req_valid) != 2'b00) begin
        grants.push_back(int'(bus.req_ready[1]));
        gcyc.push_back(cyc);
      end
      if (bus.out_valid) begin
        srcs.push_back(int'(bus.out_src));
        crcs.push_back(int'(bus.out_crc));
      end
      @(negedge clk);
    end
    check_cnt++;
    if (grants.size() !== 4 || srcs.size() !== 4)
      $display("[TB] FAIL cont_count: got grants=%0d outputs=%0d want 4 4", grants.size(), srcs.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      int g;
      int s;
      int c;
      g = (i < grants.size()) ? grants[i] : -1;
      s = (i < srcs.size()) ? srcs[i] : -1;
      c = (i < crcs.size()) ? crcs[i] : -1;
      check_cnt++;
      if (g !== exp_idx[i] || s !== exp_idx[i] || c !== exp_crc[i])
        $display("[TB] FAIL cont_order[%0d]: got grant=%0d src=%0d crc=%h want %0d %0d %h",
                 i, g, s, c, exp_idx[i], exp_idx[i], exp_crc[i]);
      else pass_cnt++;
      if (i > 0) begin
        int gap;
        gap = (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1;
        check_cnt++;
        if (gap !== 7) $display("[TB] FAIL cont_gap[%0d]: got %0d want 7", i, gap);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_valid_withdrawn();
    int n;
    bus.req_valid = 2'b01;
    bus.req_data0 = 10'h200;
    bus.req_data1 = 10'h001;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    check_cnt++;
    if (bus.req_ready !== 2'b00) $display("[TB] FAIL wd_shift_rdy: got %b want 00", bus.req_ready);
    else pass_cnt++;
    await_valid(2'b00, n);
    check_cnt++;
    if ({n[4:0], bus.out_crc, bus.out_src} !== {5'd4, 8'h2A, 1'b0})
      $display("[TB] FAIL wd_frame: got n=%0d crc=%h src=%b want 4 2a 0", n, bus.out_crc, bus.out_src);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cnt++;
      if ({bus.busy, bus.req_ready, bus.out_valid} !== 4'b0)
        $display("[TB] FAIL wd_no_grant[%0d]: got busy=%b rdy=%b vld=%b want 0 00 0",
                 i, bus.busy, bus.req_ready, bus.out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    test_reset();
    test_single_frame();
    test_requester1();
    test_backpressure();
    test_reset_mid_shift();
    test_contention();
    test_valid_withdrawn();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/crc_frame_scheduler.md
# crc_frame_scheduler

Sequencing and arbitration front end for the two-bits-per-cycle CRC LFSR datapath. Two requesters each hand over a message word through a valid/ready handshake. A round-robin arbiter grants one requester at a time. An FSM then steps an embedded 2-level unfolded serial LFSR across the message, MSB first, two bits per clock. It presents the codeword (message followed by remainder) on a valid/ready output port. The block sits between message sources and the framing/transmit logic, so one CRC engine is time-shared instead of being instantiated per source.

## Interface
- MSG_W, 10, message width in bits; must be even and at least 2
- CRC_W, 8, remainder width and generator degree
- POLY, 8'h07, generator polynomial with implicit x^CRC_W term (default x^8+x^2+x+1)
- INIT, 8'h00, LFSR preset loaded on every grant

- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low; 0 resets all state immediately
- req_valid  in  2  per-requester message valid
- req_data0  in  MSG_W  requester 0 message
- req_data1  in  MSG_W  requester 1 message
- req_ready  out  2  one-hot grant/accept; a transfer happens on req_valid[i] & req_ready[i]
- out_valid  out  1  codeword valid
- out_ready  in  1  downstream accept
- out_data  out  MSG_W+CRC_W  codeword {message, remainder}
- out_crc  out  CRC_W  remainder alone
- out_src  out  1  index of the requester that supplied the message
- busy  out  1  high in SHIFT and HOLD

## Operation
- FSM states: IDLE, SHIFT, HOLD. Reset state is IDLE.
- **IDLE**
  - If no req_valid bit is set: req_ready = 0.
  - If exactly one bit is set: that requester gets req_ready.
  - If both bits are set: the requester that is not last_grant gets req_ready.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - req_ready is combinational from req_valid and last_grant, and is asserted only in IDLE.
- **On transfer**
  - Latch the message into a shift register and the index into src.
  - Set lfsr = INIT and cnt = 0.
  - Set last_grant = index.
  - Go to SHIFT.
- **SHIFT, each cycle**
  - Apply two serial steps using the two MSBs of the shift register, higher bit first.
  - Serial step: fb = lfsr[CRC_W-1] ^ bit; lfsr = (lfsr << 1) ^ (fb ? POLY : 0).
  - Shift the message register left by 2 and increment cnt.
  - When cnt reaches MSG_W/2 - 1, go to HOLD.
- **HOLD**
  - out_valid = 1; out_crc = lfsr; out_data = {latched message, lfsr}; out_src = src.
  - All outputs stay stable until out_valid & out_ready.
  - On that handshake, go to IDLE.
- With INIT = 0 the remainder equals M(x)·x^CRC_W mod G(x). There is no reflection and no final XOR.
- out_data, out_crc and out_src are registered and hold their last value outside HOLD. out_valid alone qualifies them.
- req_valid deasserting before a grant has no effect. Data is sampled only on the transfer edge.
- req_valid on the non-granted line during SHIFT or HOLD is ignored. It keeps waiting and gets priority at the next IDLE.
- out_ready is ignored outside HOLD.
- **Reset mid-operation:** state returns to IDLE immediately and all outputs clear. last_grant = 1, and the in-flight frame is discarded and never emitted.

## Timing
- Reset values: req_ready = 0, out_valid = 0, out_data = 0, out_crc = 0, out_src = 0, busy = 0.
- Cycle 0: IDLE with a transfer.
- Cycles 1 .. MSG_W/2: SHIFT (5 cycles at the defaults).
- Cycle MSG_W/2 + 1 (cycle 6 at the defaults): out_valid high.
- If out_ready = 1 in the first HOLD cycle, IDLE follows, and a new transfer is possible one cycle later.
- Minimum frame period is MSG_W/2 + 2 clocks (7 at the defaults).
- busy rises the cycle after the transfer and falls the cycle after the output handshake.

## Test plan
- Single frame, default parameters:
  - Stimulus: req_valid = 01, req_data0 = 10'b1100000011, out_ready = 1.
  - Required: req_ready = 01 in cycle 0; out_valid at cycle 6 with out_crc = 8'h36, out_data = 18'h30336, out_src = 0.
- Requester 1 alone:
  - Stimulus: req_data1 = 10'h001.
  - Required: out_crc = 8'h07, out_data = 18'h00107, out_src = 1. Zero message 10'h000 gives out_crc = 8'h00.
- Contention:
  - Stimulus: both req_valid held high from reset release, out_ready = 1.
  - Required: grant order 0,1,0,1; transfers exactly 7 cycles apart; each out_src matches the granted requester.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles in HOLD.
  - Required: out_valid, out_data, out_crc and out_src constant; req_ready = 00 throughout; exactly one output handshake when out_ready rises.
- Reset mid-SHIFT:
  - Stimulus: reset driven to 0 in cycle 3 of a frame.
  - Required: outputs reach their reset values without waiting for a clock edge, and no codeword for that frame appears. After release, with both requesters valid, requester 0 is granted first.
- Valid withdrawn:
  - Stimulus: req_valid[1] pulses for 1 cycle while the FSM is in SHIFT.
  - Required: no transfer from requester 1, and no spurious grant in the following IDLE.
